alu_issue: RTL

//  Issue stage directly upstream of the 4-bit alu (ports a,b,f -> y,zf,of,cf). Buffers ALU commands in a

---
 rtl/alu_issue.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - command FIFO and issue stage feeding the combinational 4-bit alu
// Results and flags are registered behind a valid/ready handshake; acc tracks the last issued result.
module alu_issue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_func,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zf,
  input  logic             alu_of,
  input  logic             alu_cf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_y,
  output logic             res_zf,
  output logic             res_of,
  output logic             res_cf,
  output logic [WIDTH-1:0] acc
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [2:0]       func;
    logic             use_acc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  cmd_t             mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_y_q, res_y_d;
  logic             res_zf_q, res_zf_d;
  logic             res_of_q, res_of_d;
  logic             res_cf_q, res_cf_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  cmd_t             in_cmd;
  cmd_t             head;
  logic             nonempty;
  logic             push;
  logic             issue;

  assign in_cmd    = {cmd_func, cmd_use_acc, cmd_a, cmd_b};
  assign head      = mem_q[rd_ptr_q];
  assign nonempty  = (count_q != '0);
  assign cmd_ready = (count_q != FULL);
  assign push      = cmd_valid & cmd_ready;
  assign issue     = nonempty & (~res_valid_q | res_ready);

  assign res_valid = res_valid_q;
  assign res_y     = res_y_q;
  assign res_zf    = res_zf_q;
  assign res_of    = res_of_q;
  assign res_cf    = res_cf_q;
  assign acc       = acc_q;

  // The alu sees the head entry every cycle; an empty FIFO presents all zeros.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_f = '0;
    if (nonempty) begin
      alu_a = head.use_acc ? acc_q : head.a;
      alu_b = head.b;
      alu_f = head.func;
    end
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    res_valid_d = res_valid_q;
    res_y_d     = res_y_q;
    res_zf_d    = res_zf_q;
    res_of_d    = res_of_q;
    res_cf_d    = res_cf_q;
    acc_d       = acc_q;

    if (push) begin
      mem_d[wr_ptr_q] = in_cmd;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    if (issue) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      res_valid_d = 1'b1;
      res_y_d     = alu_y;
      acc_d       = alu_y;
      // Only add/sub carry meaningful alu flags; logic ops report zero-detect alone.
      if (alu_f <= 3'd1) begin
        res_zf_d = alu_zf;
        res_of_d = alu_of;
        res_cf_d = alu_cf;
      end else begin
        res_zf_d = (alu_y == '0);
        res_of_d = 1'b0;
        res_cf_d = 1'b0;
      end
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end

    case ({push, issue})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_zf_q    <= 1'b0;
      res_of_q    <= 1'b0;
      res_cf_q    <= 1'b0;
      acc_q       <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_y_q     <= res_y_d;
      res_zf_q    <= res_zf_d;
      res_of_q    <= res_of_d;
      res_cf_q    <= res_cf_d;
      acc_q       <= acc_d;
    end
  end

endmodule
